// File: rtl/fb_phase_detector_if.sv
// ----------------------------------------------------------------------------
// fb_phase_detector_if
// Purpose : groups the sampled clock inputs and the loop-filter facing
//           outputs of fb_phase_detector into one bundle.
// Signals :
//   ref_in    reference clock (asynchronous to the system clock)
//   fb_in     divided feedback clock (asynchronous to the system clock)
//   up, dn    steering levels towards the loop filter
//   phase_err signed edge-to-edge difference, positive = feedback lags
//   err_valid one-cycle pulse, phase_err updated
//   slip      one-cycle pulse alongside err_valid on cycle slip / timeout
//   lock      loop locked indicator
// Modports:
//   master  side that drives the clocks and consumes the results
//   slave   the detector itself
// ----------------------------------------------------------------------------
interface fb_phase_detector_if #(
  parameter int ERR_W = 8
);
  logic                    ref_in;
  logic                    fb_in;
  logic                    up;
  logic                    dn;
  logic signed [ERR_W-1:0] phase_err;
  logic                    err_valid;
  logic                    slip;
  logic                    lock;

  modport master (
    output ref_in, fb_in,
    input  up, dn, phase_err, err_valid, slip, lock
  );

  modport slave (
    input  ref_in, fb_in,
    output up, dn, phase_err, err_valid, slip, lock
  );
endinterface

// File: rtl/fb_phase_detector.sv
// ----------------------------------------------------------------------------
// fb_phase_detector
// Purpose : digital phase/frequency detector at the end of the PLL feedback
//           path. Samples ref_in and fb_in on the fast system clock, measures
//           the signed distance between their rising edges in clk cycles,
//           drives up/dn steering levels and a lock indicator.
// Ports   :
//   clk    fast system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    fb_phase_detector_if.slave (ref_in, fb_in in; up, dn, phase_err,
//          err_valid, slip, lock out)
// Parameters:
//   ERR_W     width of phase_err; saturation value is 2^(ERR_W-1)-1
//   LOCK_TOL  largest |phase_err| still counted as in-lock
//   LOCK_CNT  consecutive in-tolerance measurements needed for lock
// ----------------------------------------------------------------------------
module fb_phase_detector #(
  parameter int ERR_W    = 8,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fb_phase_detector_if.slave bus
);

  localparam int CNT_W = ERR_W - 1;
  localparam int LCW   = $clog2(LOCK_CNT + 1);

  // An all-ones counter is exactly 2^(ERR_W-1)-1, the saturation value.
  localparam logic        [CNT_W-1:0] ERR_MAX  = '1;
  localparam logic signed [ERR_W-1:0] ERR_POS  = $signed({1'b0, ERR_MAX});
  localparam logic signed [ERR_W-1:0] ERR_NEG  = -ERR_POS;
  localparam logic signed [ERR_W-1:0] TOL_POS  = ERR_W'(LOCK_TOL);
  localparam logic signed [ERR_W-1:0] TOL_NEG  = -TOL_POS;
  localparam logic        [LCW-1:0]   LOCK_MAX = LCW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    REF_LEAD,
    FB_LEAD
  } state_t;

  logic ref_s1, ref_s2, ref_d;
  logic fb_s1, fb_s2, fb_d;
  logic ref_edge, fb_edge;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic signed [ERR_W-1:0] cnt_s;

  logic                    meas_valid;
  logic                    meas_slip;
  logic signed [ERR_W-1:0] meas_err;

  logic                    up_q, dn_q;
  logic signed [ERR_W-1:0] phase_err_q;
  logic                    err_valid_q, slip_q, lock_q;
  logic [LCW-1:0]          lock_cnt, lock_cnt_n;
  logic                    in_tol;

  // Both inputs go through identical two-flop synchronizers followed by a
  // delay flop, so the edge detectors see the same latency and the relative
  // edge timing survives the clock-domain crossing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_s1 <= 1'b0;
      ref_s2 <= 1'b0;
      ref_d  <= 1'b0;
      fb_s1  <= 1'b0;
      fb_s2  <= 1'b0;
      fb_d   <= 1'b0;
    end else begin
      ref_s1 <= bus.ref_in;
      ref_s2 <= ref_s1;
      ref_d  <= ref_s2;
      fb_s1  <= bus.fb_in;
      fb_s2  <= fb_s1;
      fb_d   <= fb_s2;
    end
  end

  assign ref_edge = ref_s2 & ~ref_d;
  assign fb_edge  = fb_s2 & ~fb_d;
  assign cnt_s    = $signed({1'b0, cnt});

  // State, counter and all registered outputs. up/dn are loaded from the
  // next state so that they track the FSM state cycle for cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      phase_err_q <= '0;
      err_valid_q <= 1'b0;
      slip_q      <= 1'b0;
      lock_cnt    <= '0;
      lock_q      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      up_q        <= (state_n == REF_LEAD);
      dn_q        <= (state_n == FB_LEAD);
      err_valid_q <= meas_valid;
      slip_q      <= meas_slip;
      if (meas_valid) begin
        phase_err_q <= meas_err;
      end
      lock_cnt    <= lock_cnt_n;
      lock_q      <= (lock_cnt_n == LOCK_MAX);
    end
  end

  // Measurement FSM. A lagging edge always takes priority over a repeated
  // leading edge in the same cycle, so a genuine measurement is never turned
  // into a slip. A repeated leading edge restarts the count at 1 because that
  // edge itself becomes the new reference point.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    meas_valid = 1'b0;
    meas_slip  = 1'b0;
    meas_err   = '0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (ref_edge && fb_edge) begin
          meas_valid = 1'b1;
        end else if (ref_edge) begin
          state_n = REF_LEAD;
          cnt_n   = CNT_W'(1);
        end else if (fb_edge) begin
          state_n = FB_LEAD;
          cnt_n   = CNT_W'(1);
        end
      end
      REF_LEAD: begin
        if (fb_edge) begin
          meas_valid = 1'b1;
          meas_err   = cnt_s;
          state_n    = IDLE;
          cnt_n      = '0;
        end else if (ref_edge) begin
          meas_valid = 1'b1;
          meas_slip  = 1'b1;
          meas_err   = ERR_POS;
          cnt_n      = CNT_W'(1);
        end else if (cnt == ERR_MAX) begin
          meas_valid = 1'b1;
          meas_slip  = 1'b1;
          meas_err   = ERR_POS;
          state_n    = IDLE;
          cnt_n      = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      FB_LEAD: begin
        if (ref_edge) begin
          meas_valid = 1'b1;
          meas_err   = -cnt_s;
          state_n    = IDLE;
          cnt_n      = '0;
        end else if (fb_edge) begin
          meas_valid = 1'b1;
          meas_slip  = 1'b1;
          meas_err   = ERR_NEG;
          cnt_n      = CNT_W'(1);
        end else if (cnt == ERR_MAX) begin
          meas_valid = 1'b1;
          meas_slip  = 1'b1;
          meas_err   = ERR_NEG;
          state_n    = IDLE;
          cnt_n      = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Lock qualification works on the registered measurement, so lock moves
  // one cycle after the err_valid pulse it reacts to.
  always_comb begin
    in_tol     = (phase_err_q <= TOL_POS) && (phase_err_q >= TOL_NEG);
    lock_cnt_n = lock_cnt;
    if (err_valid_q) begin
      if (in_tol && !slip_q) begin
        if (lock_cnt != LOCK_MAX) begin
          lock_cnt_n = lock_cnt + LCW'(1);
        end
      end else begin
        lock_cnt_n = '0;
      end
    end
  end

  assign bus.up        = up_q;
  assign bus.dn        = dn_q;
  assign bus.phase_err = phase_err_q;
  assign bus.err_valid = err_valid_q;
  assign bus.slip      = slip_q;
  assign bus.lock      = lock_q;

endmodule

// File: tb/tb_fb_phase_detector.sv
// ----------------------------------------------------------------------------
// tb_fb_phase_detector
// Purpose : self-checking bench for fb_phase_detector. A timestamp based
//           model predicts every output each cycle; directed tests add
//           hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_fb_phase_detector;

  localparam int ERR_W    = 8;
  localparam int LOCK_TOL = 2;
  localparam int LOCK_CNT = 4;
  localparam int ERR_MAX  = (1 << (ERR_W - 1)) - 1;

  // Pipeline distance from the bench seeing an input rise at a clk edge to
  // the detector's registered outputs reacting (synchronizer + FSM).
  localparam int LAT = 2;

  logic clk;
  logic rst_n;

  fb_phase_detector_if #(.ERR_W(ERR_W)) bus ();

  fb_phase_detector #(
    .ERR_W   (ERR_W),
    .LOCK_TOL(LOCK_TOL),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             up;
    logic             dn;
    logic             ev;
    logic             sl;
    logic             lk;
    logic [ERR_W-1:0] err;
  } exp_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   model_active = 1'b0;

  exp_t pipe [0:LAT];
  exp_t vis;
  logic vis_lock;

  int   cyc = 0;
  int   mode;
  int   lead_t;
  int   last_err;
  int   lc;
  logic prev_r, prev_f;

  int   ev_err_q[$];
  int   ev_slip_q[$];
  int   up_cycles;
  int   dn_cycles;

  // Behavioural model: remembers which clock led and when, and derives each
  // measurement as the elapsed number of clk edges between the two rises.
  always @(posedge clk) begin
    exp_t e;
    int   err;
    bit   ev, sl, rr, fr;
    cyc = cyc + 1;
    if (!rst_n) begin
      mode         = 0;
      lead_t       = 0;
      last_err     = 0;
      lc           = 0;
      prev_r       = 1'b0;
      prev_f       = 1'b0;
      vis          = '0;
      vis_lock     = 1'b0;
      for (int i = 0; i <= LAT; i++) pipe[i] = '0;
      model_active = 1'b1;
    end else begin
      rr     = bus.ref_in & ~prev_r;
      fr     = bus.fb_in & ~prev_f;
      prev_r = bus.ref_in;
      prev_f = bus.fb_in;
      ev     = 1'b0;
      sl     = 1'b0;
      err    = 0;
      if (mode == 0) begin
        if (rr && fr) begin
          ev = 1'b1;
        end else if (rr) begin
          mode = 1;  lead_t = cyc;
        end else if (fr) begin
          mode = -1; lead_t = cyc;
        end
      end else begin
        if ((mode == 1 && fr) || (mode == -1 && rr)) begin
          ev = 1'b1; err = mode * (cyc - lead_t); mode = 0;
        end else if ((mode == 1 && rr) || (mode == -1 && fr)) begin
          ev = 1'b1; sl = 1'b1; err = mode * ERR_MAX; lead_t = cyc;
        end else if (cyc - lead_t >= ERR_MAX) begin
          ev = 1'b1; sl = 1'b1; err = mode * ERR_MAX; mode = 0;
        end
      end
      if (ev) begin
        last_err = err;
        if (err <= LOCK_TOL && err >= -LOCK_TOL && !sl)
          lc = (lc < LOCK_CNT) ? lc + 1 : LOCK_CNT;
        else
          lc = 0;
      end
      e.up  = (mode == 1);
      e.dn  = (mode == -1);
      e.ev  = ev;
      e.sl  = sl;
      e.lk  = (lc == LOCK_CNT);
      e.err = last_err[ERR_W-1:0];
      vis      = pipe[LAT-1];
      vis_lock = pipe[LAT].lk;
      for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = e;
    end
  end

  // Cycle-by-cycle comparison of every output against the model, plus
  // bookkeeping used by the directed checks.
  always @(negedge clk) begin
    logic [ERR_W+4:0] got, want;
    if (model_active) begin
      got  = {bus.up, bus.dn, bus.err_valid, bus.slip, bus.lock, bus.phase_err};
      want = {vis.up, vis.dn, vis.ev, vis.sl, vis_lock, vis.err};
      n_cmp = n_cmp + 1;
      if (got !== want) begin
        n_fail = n_fail + 1;
        $display("[TB] FAIL outputs cyc=%0d {up,dn,ev,slip,lock,err} got=%h want=%h",
                 cyc, got, want);
      end
      if (bus.err_valid === 1'b1) begin
        ev_err_q.push_back(int'(bus.phase_err));
        ev_slip_q.push_back(int'(bus.slip));
      end
      if (bus.up === 1'b1) up_cycles = up_cycles + 1;
      if (bus.dn === 1'b1) dn_cycles = dn_cycles + 1;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp = n_cmp + 1;
    if (actual !== expected) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  function automatic int err_at(input int idx);
    return (idx < ev_err_q.size()) ? ev_err_q[idx] : -9999;
  endfunction

  function automatic int slip_at(input int idx);
    return (idx < ev_slip_q.size()) ? ev_slip_q[idx] : -9999;
  endfunction

  function automatic bit in_pulse(input int at, input int i);
    return (at >= 0) && (i >= at) && (i < at + 4);
  endfunction

  task automatic clear_log();
    ev_err_q.delete();
    ev_slip_q.delete();
    up_cycles = 0;
    dn_cycles = 0;
  endtask

  // Drives 4-cycle pulses on ref_in (at ref_a and ref_b) and fb_in (at fb_a),
  // offsets in clk cycles; a negative offset means no pulse.
  task automatic apply_stimulus(input int ref_a, input int ref_b, input int fb_a,
                                input int total);
    clear_log();
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      bus.ref_in = in_pulse(ref_a, i) | in_pulse(ref_b, i);
      bus.fb_in  = in_pulse(fb_a, i);
    end
    bus.ref_in = 1'b0;
    bus.fb_in  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.ref_in = 1'b0;
    bus.fb_in  = 1'b0;
    up_cycles  = 0;
    dn_cycles  = 0;

    // Reset with toggling inputs, including a ref rise that must be dropped.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.ref_in = i[0];
      bus.fb_in  = i[1];
    end
    @(negedge clk);
    check_output("rst_up", int'(bus.up), 0);
    check_output("rst_dn", int'(bus.dn), 0);
    check_output("rst_err", int'(bus.phase_err), 0);
    check_output("rst_valid", int'(bus.err_valid), 0);
    check_output("rst_lock", int'(bus.lock), 0);
    bus.ref_in = 1'b1;
    bus.fb_in  = 1'b0;
    repeat (2) @(negedge clk);
    bus.ref_in = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_output("rst_no_event", ev_err_q.size(), 0);
    check_output("rst_no_up", up_cycles, 0);

    // Feedback lags by 5 cycles.
    apply_stimulus(0, -1, 5, 20);
    check_output("lag_events", ev_err_q.size(), 1);
    check_output("lag_err", err_at(0), 5);
    check_output("lag_up_cycles", up_cycles, 5);
    check_output("lag_dn_cycles", dn_cycles, 0);

    // Feedback leads by 3 cycles.
    apply_stimulus(3, -1, 0, 20);
    check_output("lead_events", ev_err_q.size(), 1);
    check_output("lead_err_hex", err_at(0) & 255, 'hFD);
    check_output("lead_dn_cycles", dn_cycles, 3);
    check_output("lead_up_cycles", up_cycles, 0);

    // Coincident edges four times in a row, lock on the fourth.
    for (int n = 0; n < 4; n++) begin
      apply_stimulus(0, -1, 0, 12);
      check_output("coin_err", err_at(0), 0);
      check_output("coin_updn", up_cycles + dn_cycles, 0);
      if (n == 2) check_output("coin_lock_early", int'(bus.lock), 0);
    end
    check_output("coin_lock", int'(bus.lock), 1);

    // Cycle slip: two ref rises 40 apart, fb 2 cycles after the second.
    apply_stimulus(0, 40, 42, 60);
    check_output("slip_events", ev_err_q.size(), 2);
    check_output("slip_err", err_at(0), 127);
    check_output("slip_flag", slip_at(0), 1);
    check_output("slip_after_err", err_at(1), 2);
    check_output("slip_after_flag", slip_at(1), 0);
    check_output("slip_lock", int'(bus.lock), 0);

    // Relock, then a 10-cycle error drops lock.
    for (int n = 0; n < 4; n++) apply_stimulus(0, -1, 0, 12);
    check_output("relock", int'(bus.lock), 1);
    apply_stimulus(0, -1, 10, 25);
    check_output("big_err", err_at(0), 10);
    check_output("big_err_unlock", int'(bus.lock), 0);

    // Timeout: ref only.
    apply_stimulus(0, -1, -1, 140);
    check_output("tmo_events", ev_err_q.size(), 1);
    check_output("tmo_err", err_at(0), 127);
    check_output("tmo_slip", slip_at(0), 1);
    check_output("tmo_up_cycles", up_cycles, 127);
    check_output("tmo_up_after", int'(bus.up), 0);

    // Reset in the middle of a measurement discards it.
    clear_log();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.ref_in = (i < 4);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (20) @(negedge clk);
    check_output("midrst_no_event", ev_err_q.size(), 0);
    check_output("midrst_up", int'(bus.up), 0);
    check_output("midrst_err", int'(bus.phase_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
